// File: rtl/motoro3_pkg.sv
// Shared motor PWM definitions used by both the generator and the capture block.
package motoro3_pkg;

    localparam int unsigned CNT_W_DEF     = 16;
    localparam int unsigned CLK_PERIOD_NS = 100;   // 10 MHz clk

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        LOW       = 2'd3
    } cap_state_e;

endpackage

// File: rtl/motoro3_pwm_in_filter.sv
// PWM input front end: 2-FF synchronizer, FILT_LEN-sample debounce, and edge strobes.
// Total pin-edge to o_f_lvl latency is 2 + FILT_LEN cycles for both edges.
module motoro3_pwm_in_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pwm_in,
    output logic o_f_lvl,
    output logic o_f_rise,
    output logic o_f_fall
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_lvl;
    logic       r_rise;
    logic       r_fall;
    logic [2:0] r_cnt;
    logic       w_accept;

    // FILT_LEN-th consecutive sample at the new level flips the filtered level
    assign w_accept = (r_sync2 != r_lvl) && (r_cnt == 3'(FILT_LEN - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_lvl   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pwm_in;
            r_sync2 <= r_sync1;
            r_rise  <= w_accept & r_sync2;
            r_fall  <= w_accept & ~r_sync2;
            if (r_sync2 == r_lvl) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_lvl <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    assign o_f_lvl  = r_lvl;
    assign o_f_rise = r_rise;
    assign o_f_fall = r_fall;

endmodule

// File: rtl/motoro3_pwm_capture.sv
// Measures PWM high time and period in clk cycles, flags period error and timeouts,
// and keeps a saturating sum of captured high times.
//
// state     | meaning
// IDLE      | capture disabled, counters cleared
// WAIT_RISE | armed, discarding the partial period until the first rise
// HIGH      | counting high time
// LOW       | counting low time, next rise completes a period
module motoro3_pwm_capture
    import motoro3_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned FILT_LEN = 3,
    parameter int unsigned TIMEOUT  = 16'hFFFF,
    parameter int unsigned PER_TOL  = 16'd4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pwm_in,
    input  logic             i_cap_en,
    input  logic [11:0]      i_m3r_pwm_len_want,
    input  logic             i_acc_clr,
    output logic [CNT_W-1:0] o_high_len,
    output logic [CNT_W-1:0] o_period_len,
    output logic             o_cap_valid,
    output logic             o_cap_timeout,
    output logic             o_cap_err,
    output logic [CNT_W-1:0] o_acc_high
);

    localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
    localparam int unsigned      CMP_W = (CNT_W > 12) ? CNT_W : 12;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    logic w_f_lvl, w_f_rise, w_f_fall;

    motoro3_pwm_in_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_pwm_in (i_pwm_in),
        .o_f_lvl  (w_f_lvl),
        .o_f_rise (w_f_rise),
        .o_f_fall (w_f_fall)
    );

    cap_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_high_cnt, r_low_cnt, w_high_nxt, w_low_nxt;
    logic [CNT_W-1:0] r_high_len, r_period_len, r_acc_high;
    logic             r_cap_valid, r_cap_tmo, r_cap_err;
    logic             w_cap, w_cap_tmo, w_cap_err;
    logic [CNT_W-1:0] w_cap_high, w_cap_period;
    logic [CMP_W-1:0] w_per_x, w_want_x, w_diff;

    always_comb begin
        w_state_nxt  = r_state;
        w_high_nxt   = r_high_cnt;
        w_low_nxt    = r_low_cnt;
        w_cap        = 1'b0;
        w_cap_tmo    = 1'b0;
        w_cap_high   = r_high_cnt;
        w_cap_period = sat_add(r_high_cnt, r_low_cnt);
        if (!i_cap_en) begin
            w_state_nxt = IDLE;
            w_high_nxt  = '0;
            w_low_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = WAIT_RISE;
                WAIT_RISE: begin
                    if (w_f_rise) begin
                        w_state_nxt = HIGH;
                        w_high_nxt  = CNT_W'(1);
                        w_low_nxt   = '0;
                    end
                end
                HIGH: begin
                    if (r_high_cnt >= TMO) begin
                        w_cap        = 1'b1;
                        w_cap_tmo    = 1'b1;
                        w_cap_high   = TMO;
                        w_cap_period = TMO;
                        w_state_nxt  = WAIT_RISE;
                        w_high_nxt   = '0;
                        w_low_nxt    = '0;
                    end else if (w_f_fall) begin
                        w_state_nxt = LOW;
                        w_low_nxt   = CNT_W'(1);
                    end else if (w_f_lvl) begin
                        w_high_nxt = sat_add(r_high_cnt, CNT_W'(1));
                    end
                end
                LOW: begin
                    if (r_low_cnt >= TMO) begin
                        w_cap        = 1'b1;
                        w_cap_tmo    = 1'b1;
                        w_cap_period = TMO;
                        w_state_nxt  = WAIT_RISE;
                        w_high_nxt   = '0;
                        w_low_nxt    = '0;
                    end else if (w_f_rise) begin
                        // capture and start the next high count on the same edge
                        w_cap       = 1'b1;
                        w_state_nxt = HIGH;
                        w_high_nxt  = CNT_W'(1);
                        w_low_nxt   = '0;
                    end else begin
                        w_low_nxt = sat_add(r_low_cnt, CNT_W'(1));
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_per_x   = CMP_W'(w_cap_period);
    assign w_want_x  = CMP_W'(i_m3r_pwm_len_want);
    assign w_diff    = (w_per_x >= w_want_x) ? (w_per_x - w_want_x) : (w_want_x - w_per_x);
    assign w_cap_err = (w_diff > CMP_W'(PER_TOL));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_high_cnt   <= '0;
            r_low_cnt    <= '0;
            r_high_len   <= '0;
            r_period_len <= '0;
            r_cap_valid  <= 1'b0;
            r_cap_tmo    <= 1'b0;
            r_cap_err    <= 1'b0;
            r_acc_high   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_high_cnt  <= w_high_nxt;
            r_low_cnt   <= w_low_nxt;
            r_cap_valid <= w_cap;
            if (w_cap) begin
                r_high_len   <= w_cap_high;
                r_period_len <= w_cap_period;
                r_cap_tmo    <= w_cap_tmo;
                r_cap_err    <= w_cap_err;
                r_acc_high   <= sat_add(i_acc_clr ? '0 : r_acc_high, w_cap_high);
            end else if (i_acc_clr) begin
                r_acc_high <= '0;
            end
        end
    end

    assign o_high_len    = r_high_len;
    assign o_period_len  = r_period_len;
    assign o_cap_valid   = r_cap_valid;
    assign o_cap_timeout = r_cap_tmo;
    assign o_cap_err     = r_cap_err;
    assign o_acc_high    = r_acc_high;

endmodule

// File: tb/tb_motoro3_pwm_capture.sv
// Bench for motoro3_pwm_capture: table vectors, randomized periods against an
// arithmetic period model, and hand sequences for glitch/timeout/disable/reset.
`timescale 1ns/1ps
module tb_motoro3_pwm_capture;
    import motoro3_pkg::*;

    logic        clk = 1'b0;
    logic        rst, pwm, cap_en, acc_clr;
    logic [11:0] want;
    logic [15:0] high_len, period_len, acc_high;
    logic        cap_valid, cap_timeout, cap_err;
    logic [7:0]  high8, per8, acc8;
    logic        valid8, tmo8, err8;

    always #(CLK_PERIOD_NS / 2) clk = ~clk;

    motoro3_pwm_capture #(.CNT_W(16), .FILT_LEN(3), .TIMEOUT(200), .PER_TOL(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_pwm_in(pwm), .i_cap_en(cap_en),
        .i_m3r_pwm_len_want(want), .i_acc_clr(acc_clr),
        .o_high_len(high_len), .o_period_len(period_len), .o_cap_valid(cap_valid),
        .o_cap_timeout(cap_timeout), .o_cap_err(cap_err), .o_acc_high(acc_high));

    // narrow instance used to reach accumulator saturation quickly
    motoro3_pwm_capture #(.CNT_W(8), .FILT_LEN(3), .TIMEOUT(255), .PER_TOL(4)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_pwm_in(pwm), .i_cap_en(cap_en),
        .i_m3r_pwm_len_want(want), .i_acc_clr(acc_clr),
        .o_high_len(high8), .o_period_len(per8), .o_cap_valid(valid8),
        .o_cap_timeout(tmo8), .o_cap_err(err8), .o_acc_high(acc8));

    typedef struct { int high; int per; bit tmo; bit err; } cap_t;
    typedef struct { int hi; int lo; int n; int want; int e_high; int e_per; bit e_err; } vec_t;

    cap_t cap_q[$];
    int   n_cap8 = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        if (!rst && cap_valid)
            cap_q.push_back('{int'(high_len), int'(period_len), cap_timeout, cap_err});
        if (!rst && valid8 && !tmo8 && !err8) n_cap8++;
    end

    initial begin
        #(CLK_PERIOD_NS * 100000);
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic seg(input bit lvl, input int n);
        pwm = lvl;
        step(n);
    endtask

    task automatic chk_cap(input string name, input int idx, input int e_high, input int e_per,
                           input bit e_tmo, input bit e_err);
        if (idx < cap_q.size()) begin
            chk($sformatf("%s[%0d].high", name, idx), cap_q[idx].high, e_high);
            chk($sformatf("%s[%0d].period", name, idx), cap_q[idx].per, e_per);
            chk($sformatf("%s[%0d].timeout", name, idx), int'(cap_q[idx].tmo), int'(e_tmo));
            chk($sformatf("%s[%0d].err", name, idx), int'(cap_q[idx].err), int'(e_err));
        end
    endtask

    task automatic check_caps(input string name, input int n_exp, input int e_high, input int e_per,
                              input bit e_tmo, input bit e_err);
        chk({name, ".count"}, cap_q.size(), n_exp);
        for (int i = 0; i < n_exp; i++) chk_cap(name, i, e_high, e_per, e_tmo, e_err);
        cap_q.delete();
    endtask

    task automatic check_zero(input string name);
        chk({name, ".high"}, int'(high_len), 0);
        chk({name, ".period"}, int'(period_len), 0);
        chk({name, ".valid"}, int'(cap_valid), 0);
        chk({name, ".timeout"}, int'(cap_timeout), 0);
        chk({name, ".err"}, int'(cap_err), 0);
        chk({name, ".acc"}, int'(acc_high), 0);
        chk({name, ".acc8"}, int'(acc8), 0);
    endtask

    // n full periods are measured; the trailing period is dropped by disabling
    task automatic run_vec(input string name, input int hi, input int lo, input int n,
                           input int w, input int e_high, input int e_per, input bit e_err);
        cap_en = 1'b0; pwm = 1'b0; want = 12'(w);
        acc_clr = 1'b1; step(1); acc_clr = 1'b0;
        step(5);
        cap_q.delete();
        cap_en = 1'b1; step(4);
        repeat (n + 1) begin
            seg(1'b1, hi);
            seg(1'b0, lo);
        end
        step(8);
        cap_en = 1'b0; step(1);
        chk({name, ".acc"}, int'(acc_high), (n * e_high > 65535) ? 65535 : n * e_high);
        check_caps(name, n, e_high, e_per, 1'b0, e_err);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{40, 60, 3, 100, 40, 100, 1'b0};
        vecs[1] = '{46, 60, 2, 100, 46, 106, 1'b1};
        vecs[2] = '{44, 60, 2, 100, 44, 104, 1'b0};
        vecs[3] = '{40, 56, 2, 100, 40, 96, 1'b0};
        vecs[4] = '{40, 55, 1, 100, 40, 95, 1'b1};
        vecs[5] = '{3, 3, 2, 6, 3, 6, 1'b0};
        vecs[6] = '{180, 120, 1, 300, 180, 300, 1'b0};
        vecs[7] = '{10, 90, 2, 4000, 10, 100, 1'b1};

        rst = 1'b1; pwm = 1'b0; cap_en = 1'b0; acc_clr = 1'b0; want = 12'd100;
        step(2);
        check_zero("reset");
        rst = 1'b0;
        step(2);

        foreach (vecs[i])
            run_vec($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].n, vecs[i].want,
                    vecs[i].e_high, vecs[i].e_per, vecs[i].e_err);

        for (int r = 0; r < 8; r++) begin
            int hi, lo, n, w, p, d;
            hi = $urandom_range(3, 150);
            lo = $urandom_range(3, 150);
            n  = $urandom_range(1, 3);
            p  = hi + lo;
            w  = p + $urandom_range(0, 16) - 8;
            d  = (p > w) ? p - w : w - p;
            run_vec($sformatf("rand%0d", r), hi, lo, n, w, hi, p, d > 4);
        end

        // 2-cycle low glitch inside the second high must merge into it
        want = 12'd100; cap_en = 1'b1; step(4);
        seg(1'b1, 40); seg(1'b0, 60);
        seg(1'b1, 20); seg(1'b0, 2); seg(1'b1, 18); seg(1'b0, 60);
        seg(1'b1, 40); seg(1'b0, 60);
        seg(1'b1, 10);
        cap_en = 1'b0; seg(1'b0, 10);
        check_caps("glitch", 3, 40, 100, 1'b0, 1'b0);

        // high timeout, then a rise from WAIT_RISE, then low timeout
        cap_en = 1'b1; step(4);
        seg(1'b1, 300); seg(1'b0, 50);
        seg(1'b1, 40); seg(1'b0, 300);
        cap_en = 1'b0; step(2);
        chk("timeout.count", cap_q.size(), 2);
        chk_cap("timeout", 0, 200, 200, 1'b1, 1'b1);
        chk_cap("timeout", 1, 40, 200, 1'b1, 1'b1);
        cap_q.delete();

        // disable mid-high: that period and the following partial one are dropped
        cap_en = 1'b1; step(4);
        seg(1'b1, 40); seg(1'b0, 60);
        seg(1'b1, 40); seg(1'b0, 60);
        seg(1'b1, 20); cap_en = 1'b0; step(10); cap_en = 1'b1; step(10);
        seg(1'b0, 60);
        seg(1'b1, 40); seg(1'b0, 60);
        seg(1'b1, 40); seg(1'b0, 60);
        seg(1'b1, 10);
        cap_en = 1'b0; seg(1'b0, 10);
        check_caps("disable", 4, 40, 100, 1'b0, 1'b0);

        // accumulator saturation on the 8-bit instance
        acc_clr = 1'b1; step(1); acc_clr = 1'b0;
        want = 12'd160; n_cap8 = 0; cap_en = 1'b1; step(4);
        repeat (5) begin
            seg(1'b1, 100);
            seg(1'b0, 60);
        end
        step(8);
        cap_en = 1'b0; step(2);
        check_caps("sat16", 4, 100, 160, 1'b0, 1'b0);
        chk("sat16.acc", int'(acc_high), 400);
        chk("sat8.acc", int'(acc8), 255);
        chk("sat8.high", int'(high8), 100);
        chk("sat8.period", int'(per8), 160);
        chk("sat8.count", n_cap8, 4);

        // capture latency and accClr coincident with a capture
        want = 12'd100; acc_clr = 1'b1; step(1); acc_clr = 1'b0;
        cap_en = 1'b1; step(4);
        seg(1'b1, 40); seg(1'b0, 60);
        seg(1'b1, 40); seg(1'b0, 60);
        seg(1'b1, 40); seg(1'b0, 60);
        chk("acc.before", int'(acc_high), 80);
        pwm = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk($sformatf("latency.valid_c%0d", i + 1), int'(cap_valid), 0);
        end
        acc_clr = 1'b1;
        step(1);
        acc_clr = 1'b0;
        chk("latency.valid_c6", int'(cap_valid), 1);
        chk("accclr.acc", int'(acc_high), 40);
        chk("accclr.high", int'(high_len), 40);
        chk("accclr.period", int'(period_len), 100);
        step(1);
        chk("latency.pulse_end", int'(cap_valid), 0);

        // reset in the middle of a high phase
        step(10);
        rst = 1'b1; step(1);
        check_zero("midrst");
        rst = 1'b0; pwm = 1'b0; cap_en = 1'b0;
        step(10);
        cap_q.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
